alu_mc: RTL

Multi-cycle, handshaked arithmetic logic unit: the parametrised sequential successor to the team's combinational ALU. It adds iterative unsigned multiply and divide, full carry/overflow/divide-by-zero flags, and valid/ready flow control on both sides. It sits between an operand-issue stage and a writeback stage, and holds at most one operation in flight.

---
 rtl/alu_mc.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle handshaked ALU.
// Single-cycle ops (logic, add/sub, shifts, illegal, divide-by-zero) finish
// in the accept cycle. MUL/MULH use shift-add and DIVU/MODU use restoring
// division, one step per cycle for BITWIDTH cycles. At most one operation
// is in flight. result/flags are registered and stay unchanged until the
// next completion.
module alu_mc #(
    parameter int BITWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          op,
    input  logic [BITWIDTH-1:0] opA,
    input  logic [BITWIDTH-1:0] opB,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] result,
    output logic [5:0]          flags
);

    localparam int SW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam int CW = SW;
    localparam int MSB = BITWIDTH - 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BITWIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SAR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_MODU = 4'd11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;

    // Operation captured at accept; only used while BUSY.
    logic [3:0]            op_q;
    logic [BITWIDTH-1:0]   a_q;
    logic [BITWIDTH-1:0]   b_q;
    // MUL: {partial high, remaining multiplier}; DIV: {remainder, dividend/quotient}.
    logic [2*BITWIDTH-1:0] acc;

    logic                  accept;
    logic                  last_step;

    logic [BITWIDTH:0]     sum_ext;
    logic [BITWIDTH:0]     dif_ext;
    logic [BITWIDTH-1:0]   sc_res;
    logic [5:0]            sc_flags;
    logic                  sc_multi;

    logic [BITWIDTH:0]     mul_sum;
    logic [2*BITWIDTH-1:0] mul_next;
    logic [BITWIDTH:0]     div_sh;
    logic [BITWIDTH:0]     div_diff;
    logic [BITWIDTH-1:0]   div_rem;
    logic [2*BITWIDTH-1:0] div_next;
    logic [2*BITWIDTH-1:0] acc_next;
    logic                  is_div_q;
    logic [BITWIDTH-1:0]   mc_res;
    logic                  mc_carry;
    logic [5:0]            mc_flags;

    // Assemble {illegal, divzero, carry, overflow, sign, zero}.
    function automatic logic [5:0] pack_flags(
        input logic                ill,
        input logic                dz,
        input logic                cy,
        input logic                ov,
        input logic [BITWIDTH-1:0] r
    );
        return {ill, dz, cy, ov, r[MSB], (r == '0)};
    endfunction

    // Shifts by B[SW-1:0]; an amount of BITWIDTH or more saturates the result.
    function automatic logic [BITWIDTH-1:0] shift_calc(
        input logic [3:0]          code,
        input logic [BITWIDTH-1:0] a,
        input logic [BITWIDTH-1:0] b
    );
        logic signed [BITWIDTH-1:0] sa;
        logic [SW-1:0]              amt;
        logic                       big;
        sa  = a;
        amt = b[SW-1:0];
        big = (b >= BITWIDTH'(BITWIDTH));
        case (code)
            OP_SHL:  return big ? '0 : (a << amt);
            OP_SHR:  return big ? '0 : (a >> amt);
            default: return big ? {BITWIDTH{a[MSB]}} : $unsigned(sa >>> amt);
        endcase
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && (state == S_IDLE);
    assign last_step = (state == S_BUSY) && (cnt == LAST_CNT);

    // Single-cycle result/flags from the live inputs, plus multi-cycle decode.
    always_comb begin
        logic ill, dz, cy, ov;
        ill      = 1'b0;
        dz       = 1'b0;
        cy       = 1'b0;
        ov       = 1'b0;
        sc_res   = '0;
        sc_multi = 1'b0;
        sum_ext  = {1'b0, opA} + {1'b0, opB};
        dif_ext  = {1'b0, opA} - {1'b0, opB};
        case (op)
            OP_ADD: begin
                sc_res = sum_ext[BITWIDTH-1:0];
                cy     = sum_ext[BITWIDTH];
                ov     = (opA[MSB] == opB[MSB]) && (sum_ext[MSB] != opA[MSB]);
            end
            OP_SUB: begin
                sc_res = dif_ext[BITWIDTH-1:0];
                cy     = dif_ext[BITWIDTH];
                ov     = (opA[MSB] != opB[MSB]) && (dif_ext[MSB] != opA[MSB]);
            end
            OP_AND: sc_res = opA & opB;
            OP_OR:  sc_res = opA | opB;
            OP_XOR: sc_res = opA ^ opB;
            OP_SHL, OP_SHR, OP_SAR: sc_res = shift_calc(op, opA, opB);
            OP_MUL, OP_MULH: sc_multi = 1'b1;
            OP_DIVU: begin
                if (opB == '0) begin
                    sc_res = '1;
                    dz     = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
            OP_MODU: begin
                if (opB == '0) begin
                    sc_res = opA;
                    dz     = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        sc_flags = pack_flags(ill, dz, cy, ov, sc_res);
    end

    // One shift-add or restoring-divide step, and the final result on the last step.
    always_comb begin
        mul_sum  = {1'b0, acc[2*BITWIDTH-1:BITWIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc[BITWIDTH-1:1]};
        div_sh   = {acc[2*BITWIDTH-1:BITWIDTH], acc[BITWIDTH-1]};
        div_diff = div_sh - {1'b0, b_q};
        div_rem  = div_diff[BITWIDTH] ? div_sh[BITWIDTH-1:0] : div_diff[BITWIDTH-1:0];
        div_next = {div_rem, acc[BITWIDTH-2:0], ~div_diff[BITWIDTH]};
        is_div_q = (op_q == OP_DIVU) || (op_q == OP_MODU);
        acc_next = is_div_q ? div_next : mul_next;
        mc_res   = '0;
        mc_carry = 1'b0;
        case (op_q)
            OP_MUL: begin
                mc_res   = mul_next[BITWIDTH-1:0];
                mc_carry = (mul_next[2*BITWIDTH-1:BITWIDTH] != '0);
            end
            OP_MULH: mc_res = mul_next[2*BITWIDTH-1:BITWIDTH];
            OP_DIVU: mc_res = div_next[BITWIDTH-1:0];
            OP_MODU: mc_res = div_next[2*BITWIDTH-1:BITWIDTH];
            default: mc_res = '0;
        endcase
        mc_flags = pack_flags(1'b0, 1'b0, mc_carry, 1'b0, mc_res);
    end

    // Control FSM and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state <= sc_multi ? S_BUSY : S_DONE;
                        cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    if (cnt == LAST_CNT) begin
                        state <= S_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Operand capture at accept and iteration of the work register.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op;
            a_q  <= opA;
            b_q  <= opB;
            acc  <= ((op == OP_DIVU) || (op == OP_MODU)) ? {{BITWIDTH{1'b0}}, opA}
                                                         : {{BITWIDTH{1'b0}}, opB};
        end else if (state == S_BUSY) begin
            acc <= acc_next;
        end
    end

    // Registered result/flags, updated only on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
        end else if (accept && !sc_multi) begin
            result <= sc_res;
            flags  <= sc_flags;
        end else if (last_step) begin
            result <= mc_res;
            flags  <= mc_flags;
        end
    end

endmodule
